// File: rtl/spi_mem_bridge_if.sv
// spi_mem_bridge_if: serial pins, lock-out and memory-port bundle between a host loader and spi_mem_bridge.
interface spi_mem_bridge_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int NUM_CH = 2
) ();
    logic [NUM_CH-1:0]        cs_n;
    logic                     mosi;
    logic                     miso;
    logic                     proc_busy;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic [NUM_CH-1:0]        mem_wen;
    logic [NUM_CH*DATA_W-1:0] mem_rdata;
    logic                     frame_done;
    logic                     err;

    modport master (
        output cs_n, mosi, proc_busy, mem_rdata,
        input  miso, mem_addr, mem_wdata, mem_wen, frame_done, err
    );

    modport slave (
        input  cs_n, mosi, proc_busy, mem_rdata,
        output miso, mem_addr, mem_wdata, mem_wen, frame_done, err
    );
endinterface

// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge: SPI-style slave that writes/reads back per-channel memories, refusing frames while proc_busy.
// Define SPI_MEM_BRIDGE_AUTOINC_EN for burst mode (auto-incrementing address while cs_n stays low).
module spi_mem_bridge #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int NUM_CH = 2
) (
    input logic             clk,
    input logic             rst_n,
    spi_mem_bridge_if.slave bus
);
    localparam int CH_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int MAX_W = DATA_W > ADDR_W ? DATA_W : ADDR_W;
    localparam int CNT_W = MAX_W > 1 ? $clog2(MAX_W) : 1;
`ifdef SPI_MEM_BRIDGE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, WRITE, RDATA, HOLD} state_e;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d, low_idx;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d, rd_word;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cs_sel;

    assign cs_sel        = bus.cs_n[ch_q];
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = data_q;
    assign bus.mem_wen   = (state_q == WRITE) ? (NUM_CH'(1) << ch_q) : '0;
    assign bus.miso      = (state_q == RDATA) && rd_word[cnt_q];
    assign bus.frame_done = done_q;
    assign bus.err       = err_q;

    // Readback word is taken straight from the addressed memory so the first bit is ready right after the address.
    always_comb begin
        low_idx = '0;
        rd_word = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!bus.cs_n[i]) low_idx = CH_W'(i);
            if (ch_q == CH_W'(i)) rd_word = bus.mem_rdata[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = err_q;
        if (state_q inside {CMD, ADDR, WDATA, RDATA} && cs_sel) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!(&bus.cs_n)) begin
                        if (bus.proc_busy) begin
                            err_d = 1'b1;
                        end else if ($onehot(~bus.cs_n)) begin
                            state_d = CMD;
                            ch_d    = low_idx;
                        end else begin
                            err_d   = 1'b1;
                            state_d = HOLD;
                        end
                    end
                end
                CMD: begin
                    cmd_d   = bus.mosi;
                    cnt_d   = CNT_W'(ADDR_W - 1);
                    state_d = ADDR;
                end
                ADDR: begin
                    addr_d = ADDR_W'({addr_q, bus.mosi});
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        cnt_d   = CNT_W'(DATA_W - 1);
                        state_d = cmd_q ? WDATA : RDATA;
                    end
                end
                WDATA: begin
                    data_d = DATA_W'({data_q, bus.mosi});
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == '0) state_d = WRITE;
                end
                WRITE: begin
                    done_d  = 1'b1;
                    state_d = HOLD;
                    if (AUTOINC && !cs_sel) begin
                        state_d = WDATA;
                        cnt_d   = CNT_W'(DATA_W - 1);
                        addr_d  = addr_q + 1'b1;
                    end
                end
                RDATA: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        done_d  = 1'b1;
                        state_d = HOLD;
                        if (AUTOINC) begin
                            state_d = RDATA;
                            cnt_d   = CNT_W'(DATA_W - 1);
                            addr_d  = addr_q + 1'b1;
                        end
                    end
                end
                HOLD: state_d = (&bus.cs_n) ? IDLE : HOLD;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            cmd_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_spi_mem_bridge.sv
// tb_spi_mem_bridge: directed scoreboard bench for spi_mem_bridge; define SPI_MEM_BRIDGE_AUTOINC_EN to add the burst step.
module tb_spi_mem_bridge;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    logic [13:0] wr_exp[$];
    logic        miso_exp[$];
    logic [7:0]  rd_val;

    spi_mem_bridge_if #(.DATA_W(8), .ADDR_W(4), .NUM_CH(2)) bus ();
    spi_mem_bridge #(.DATA_W(8), .ADDR_W(4), .NUM_CH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [1:0] cs);
        @(negedge clk);
        bus.cs_n = cs;
    endtask

    task automatic send(input int n, input logic [31:0] v);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            bus.mosi = v[i];
        end
    endtask

    // Every write strobe must match the oldest expected {wen, addr, wdata}.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.frame_done) done_cnt++;
            if (bus.mem_wen != '0) begin
                if (wr_exp.size() == 0) chk("unexpected_write", {bus.mem_wen, bus.mem_addr, bus.mem_wdata}, 32'h0);
                else chk("write", {bus.mem_wen, bus.mem_addr, bus.mem_wdata}, wr_exp.pop_front());
            end
        end
    end

    initial begin
        bus.cs_n = 2'b11;
        bus.mosi = 1'b0;
        bus.proc_busy = 1'b0;
        bus.mem_rdata = {8'h3C, 8'h00};
        #1 rst_n = 1'b0;
        #1;
        chk("rst_wen", bus.mem_wen, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_miso", bus.miso, 0);
        chk("rst_done", bus.frame_done, 0);
        chk("rst_err", bus.err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        start(2'b10);
        wr_exp.push_back({2'b01, 4'h5, 8'hA3});
        send(1, 1);
        send(4, 4'h5);
        send(8, 8'hA3);
        @(negedge clk);
        chk("write_wen", bus.mem_wen, 2'b01);
        chk("write_done_early", bus.frame_done, 0);
        @(negedge clk);
        #1;
        chk("write_done", bus.frame_done, 1);
        chk("write_wen_off", bus.mem_wen, 0);
        chk("write_err", bus.err, 0);
        chk("write_done_cnt", done_cnt, 1);
        bus.cs_n = 2'b11;
        @(negedge clk);
        #1 chk("write_done_pulse", bus.frame_done, 0);

        start(2'b01);
        send(1, 0);
        send(4, 4'h2);
        #1 chk("read_pre_miso", bus.miso, 0);
        rd_val = 8'h3C;
        for (int k = 0; k < 8; k++) miso_exp.push_back(rd_val[7-k]);
        repeat (8) begin
            @(negedge clk);
            chk("read_miso", bus.miso, miso_exp.pop_front());
        end
        @(negedge clk);
        #1;
        chk("read_done", bus.frame_done, 1);
        chk("read_addr", bus.mem_addr, 4'h2);
        chk("read_done_cnt", done_cnt, 2);
        bus.cs_n = 2'b11;

        start(2'b10);
        send(1, 1);
        send(4, 4'h7);
        send(3, 3'b101);
        @(negedge clk);
        bus.cs_n = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_done_cnt", done_cnt, 2);
        chk("abort_err", bus.err, 0);
        start(2'b10);
        wr_exp.push_back({2'b01, 4'h7, 8'h5A});
        send(1, 1);
        send(4, 4'h7);
        send(8, 8'h5A);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("recover_done", bus.frame_done, 1);
        chk("recover_queue", wr_exp.size(), 0);
        bus.cs_n = 2'b11;

        start(2'b00);
        @(negedge clk);
        #1 chk("conflict_err", bus.err, 1);
        bus.cs_n = 2'b10;
        send(1, 1);
        send(4, 4'hC);
        send(8, 8'hFF);
        repeat (3) @(negedge clk);
        #1 chk("conflict_done_cnt", done_cnt, 3);
        bus.cs_n = 2'b11;
        @(negedge clk);

        start(2'b01);
        send(1, 1);
        send(4, 4'h9);
        send(4, 4'hF);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_addr", bus.mem_addr, 0);
        chk("arst_wdata", bus.mem_wdata, 0);
        chk("arst_wen", bus.mem_wen, 0);
        chk("arst_miso", bus.miso, 0);
        chk("arst_done", bus.frame_done, 0);
        chk("arst_err", bus.err, 0);
        bus.cs_n = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        send(16, 32'hA5F0);
        #1;
        chk("arst_done_cnt", done_cnt, 3);
        chk("arst_err_after", bus.err, 0);

        bus.proc_busy = 1'b1;
        start(2'b10);
        send(1, 1);
        send(4, 4'h3);
        send(8, 8'h77);
        @(negedge clk);
        #1;
        chk("busy_err", bus.err, 1);
        chk("busy_done_cnt", done_cnt, 3);
        bus.cs_n = 2'b11;
        @(negedge clk);
        bus.proc_busy = 1'b0;

`ifdef SPI_MEM_BRIDGE_AUTOINC_EN
        start(2'b10);
        wr_exp.push_back({2'b01, 4'hF, 8'h11});
        wr_exp.push_back({2'b01, 4'h0, 8'h22});
        send(1, 1);
        send(4, 4'hF);
        send(8, 8'h11);
        @(negedge clk);
        send(8, 8'h22);
        @(negedge clk);
        bus.cs_n = 2'b11;
        repeat (2) @(negedge clk);
        #1 chk("burst_done_cnt", done_cnt, 5);
`endif

        @(negedge clk);
        chk("queue_drained", wr_exp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
